// File: rtl/avr_core_mc_pkg.sv
//==============================================================================
// Module   : avr_core_mc_pkg
// Brief    : Shared encodings, state and ALU-control types for the AVR subset core.
// Revision : 1.0
//==============================================================================
`default_nettype none

package avr_core_mc_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SBC = 3'd3,
        ALU_AND = 3'd4,
        ALU_EOR = 3'd5,
        ALU_OR  = 3'd6,
        ALU_MOV = 3'd7
    } alu_op_t;

    localparam logic [5:0] OPC_ADD = 6'b000011;
    localparam logic [5:0] OPC_ADC = 6'b000111;
    localparam logic [5:0] OPC_SUB = 6'b000110;
    localparam logic [5:0] OPC_SBC = 6'b000010;
    localparam logic [5:0] OPC_CP  = 6'b000101;
    localparam logic [5:0] OPC_AND = 6'b001000;
    localparam logic [5:0] OPC_EOR = 6'b001001;
    localparam logic [5:0] OPC_OR  = 6'b001010;
    localparam logic [5:0] OPC_MOV = 6'b001011;

    localparam logic [3:0] OPC4_LDI  = 4'hE;
    localparam logic [3:0] OPC4_RJMP = 4'hC;
    localparam logic [5:0] OPC_BRBS  = 6'b111100;
    localparam logic [5:0] OPC_BRBC  = 6'b111101;

    localparam logic [15:0] INSTR_BREAK = 16'h9598;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    typedef struct packed {
        logic    is_alu;
        logic    wb;
        logic    flags;
        alu_op_t op;
    } alu_ctl_t;

    // Two-register ALU instructions: CP is a SUB without writeback, MOV leaves flags alone.
    function automatic alu_ctl_t decode_alu(input logic [5:0] opc);
        alu_ctl_t ctl;
        ctl.is_alu = 1'b1;
        ctl.wb     = 1'b1;
        ctl.flags  = 1'b1;
        ctl.op     = ALU_ADD;
        case (opc)
            OPC_ADD: ctl.op = ALU_ADD;
            OPC_ADC: ctl.op = ALU_ADC;
            OPC_SUB: ctl.op = ALU_SUB;
            OPC_SBC: ctl.op = ALU_SBC;
            OPC_CP:  begin ctl.op = ALU_SUB; ctl.wb = 1'b0; end
            OPC_AND: ctl.op = ALU_AND;
            OPC_EOR: ctl.op = ALU_EOR;
            OPC_OR:  ctl.op = ALU_OR;
            OPC_MOV: begin ctl.op = ALU_MOV; ctl.flags = 1'b0; end
            default: begin ctl.is_alu = 1'b0; ctl.wb = 1'b0; ctl.flags = 1'b0; end
        endcase
        return ctl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avr_alu_flags.sv
//==============================================================================
// Module   : avr_alu_flags
// Brief    : Combinational 8-bit ALU producing result plus C/Z/N/V flags.
// Revision : 1.0
//==============================================================================
`default_nettype none

module avr_alu_flags
    import avr_core_mc_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       z_old,
    output logic [7:0] result,
    output logic       c,
    output logic       z,
    output logic       n,
    output logic       v
);

    logic       w_use_c;
    logic [8:0] w_add;
    logic [8:0] w_sub;

    assign w_use_c = ((op == ALU_ADC) || (op == ALU_SBC)) ? cin : 1'b0;
    assign w_add   = {1'b0, a} + {1'b0, b} + {8'd0, w_use_c};
    // Bit 8 of the 9-bit difference is the borrow: set exactly when a < b + cin.
    assign w_sub   = {1'b0, a} - {1'b0, b} - {8'd0, w_use_c};

    always_comb begin
        result = b;
        c      = cin;
        v      = 1'b0;
        case (op)
            ALU_ADD, ALU_ADC: begin
                result = w_add[7:0];
                c      = w_add[8];
                v      = (a[7] & b[7] & ~result[7]) | (~a[7] & ~b[7] & result[7]);
            end
            ALU_SUB, ALU_SBC: begin
                result = w_sub[7:0];
                c      = w_sub[8];
                v      = (a[7] & ~b[7] & ~result[7]) | (~a[7] & b[7] & result[7]);
            end
            ALU_AND: result = a & b;
            ALU_EOR: result = a ^ b;
            ALU_OR:  result = a | b;
            default: result = b;
        endcase
        n = result[7];
        // SBC chains Z across multi-byte compares, so it can only clear Z.
        z = (result == 8'h00) && ((op != ALU_SBC) || z_old);
    end

endmodule

`default_nettype wire

// File: rtl/avr_core_mc.sv
//==============================================================================
// Module   : avr_core_mc
// Brief    : Multi-cycle AVR subset core, FETCH/EXECUTE sequencer with imem handshake.
// Revision : 1.0
//==============================================================================
`default_nettype none

module avr_core_mc
    import avr_core_mc_pkg::*;
#(
    parameter int PC_WIDTH = 10,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                imem_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instruction,
    output logic [5:0]          opcode,
    output logic [4:0]          rf1,
    output logic [4:0]          rf2,
    output logic [7:0]          a,
    output logic [7:0]          b,
    output logic [7:0]          sum,
    output logic [3:0]          sreg,
    output logic                halted
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [3:0]          sreg_q, sreg_d;
    logic [7:0]          rf_q [32];

    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [7:0]          wb_data;

    logic [4:0]          w_rd, w_rr;
    alu_ctl_t            w_ctl;
    logic                w_is_ldi, w_is_rjmp, w_is_brbs, w_is_brbc, w_is_break;
    logic                w_flag_bit, w_br_taken;
    logic signed [11:0]  w_k12;
    logic signed [6:0]   w_k7;
    logic [PC_WIDTH-1:0] w_pc_inc, w_rjmp_tgt, w_br_tgt;
    logic [7:0]          w_alu_res;
    logic                w_c, w_z, w_n, w_v;

    assign w_rd       = instr_q[8:4];
    assign w_rr       = {instr_q[9], instr_q[3:0]};
    assign w_ctl      = decode_alu(instr_q[15:10]);
    assign w_is_ldi   = (instr_q[15:12] == OPC4_LDI);
    assign w_is_rjmp  = (instr_q[15:12] == OPC4_RJMP);
    assign w_is_brbs  = (instr_q[15:10] == OPC_BRBS);
    assign w_is_brbc  = (instr_q[15:10] == OPC_BRBC);
    assign w_is_break = (instr_q == INSTR_BREAK);

    // Bit selects 4..7 name no flag and read as zero.
    assign w_flag_bit = instr_q[2] ? 1'b0 : sreg_q[instr_q[1:0]];
    assign w_br_taken = (w_is_brbs & w_flag_bit) | (w_is_brbc & ~w_flag_bit);

    // Offsets sign-extend (or truncate) to PC width; the sum wraps naturally.
    assign w_k12      = instr_q[11:0];
    assign w_k7       = instr_q[9:3];
    assign w_pc_inc   = pc_q + PC_WIDTH'(1);
    assign w_rjmp_tgt = w_pc_inc + PC_WIDTH'(w_k12);
    assign w_br_tgt   = w_pc_inc + PC_WIDTH'(w_k7);

    assign a = rf_q[w_rd];
    assign b = rf_q[w_rr];

    avr_alu_flags u_alu (
        .op     (w_ctl.op),
        .a      (a),
        .b      (b),
        .cin    (sreg_q[SREG_C]),
        .z_old  (sreg_q[SREG_Z]),
        .result (w_alu_res),
        .c      (w_c),
        .z      (w_z),
        .n      (w_n),
        .v      (w_v)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_WIDTH'(RESET_PC);
            instr_q <= 16'h0000;
            sreg_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        sreg_d  = sreg_q;
        wb_en   = 1'b0;
        wb_addr = w_rd;
        wb_data = w_alu_res;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = w_pc_inc;
                if (w_is_break) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end else if (w_ctl.is_alu) begin
                    wb_en = w_ctl.wb;
                    if (w_ctl.flags) begin
                        sreg_d = {w_v, w_n, w_z, w_c};
                    end
                end else if (w_is_ldi) begin
                    wb_en   = 1'b1;
                    wb_addr = {1'b1, instr_q[7:4]};
                    wb_data = {instr_q[11:8], instr_q[3:0]};
                end else if (w_is_rjmp) begin
                    pc_d = w_rjmp_tgt;
                end else if (w_br_taken) begin
                    pc_d = w_br_tgt;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign opcode      = instr_q[15:10];
    assign rf1         = w_rd;
    assign rf2         = w_rr;
    assign sum         = w_alu_res;
    assign sreg        = sreg_q;
    assign halted      = (state_q == S_HALT);

endmodule

`default_nettype wire
